// File: rtl/preamble_stuff_tx.sv
// -----------------------------------------------------------------------------
// preamble_stuff_tx
//
// Serial frame transmitter for links whose receiver hunts for the pattern 1010
// with an overlapping Mealy detector. Each accepted payload goes out as the
// preamble 1010, then the payload MSB first, with stuff 1s inserted so that
// the only 1010 anywhere on the line ends on the final preamble 0. A frame is
// followed by GAP_BITS idle zeros.
//
// Parameters:
//   DATA_W    payload width in bits (2..32)
//   GAP_BITS  idle 0 bits driven after each frame (>= 1)
//
// Build option:
//   PREAMBLE_TX_PARITY_EN  when defined, an even-parity bit (XOR of the payload
//                          bits, stuff bits excluded) follows the last payload
//                          bit and gets the same stuffing treatment.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   tx_data     payload, sampled only on the handshake edge
//   tx_valid    producer has a payload
//   tx_ready    block can accept a payload (IDLE and not in reset)
//   sout        registered serial line, 0 when idle
//   sout_en     high while sout carries a frame bit
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse with the last gap bit
// -----------------------------------------------------------------------------
module preamble_stuff_tx #(
   parameter int DATA_W   = 8,
   parameter int GAP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              sout,
   output logic              sout_en,
   output logic              busy,
   output logic              frame_done
);

`ifdef PREAMBLE_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int BODY_BITS = DATA_W + PAR_BITS;
   localparam int RW        = $clog2(BODY_BITS + 1);
   localparam int BCW       = $clog2(2 * DATA_W + 7);
   localparam int GW        = $clog2(GAP_BITS + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS);

   // state_q names the phase of the bit currently on sout
   typedef enum logic [2:0] {IDLE, PRE, DATA, TAIL, GAP} state_t;

   state_t            state_q, state_d;
   logic              sout_q, sout_d;
   logic              en_q, en_d;
   logic              busy_q;
   logic              done_q, done_d;
   logic [2:0]        hist_q, hist_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              par_q, par_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [BCW-1:0]    bcnt_q, bcnt_d;
   logic [GW-1:0]     gap_q, gap_d, gap_inc;
   logic              body, enter_gap;

   assign tx_ready   = (state_q == IDLE) && !rst;
   assign sout       = sout_q;
   assign sout_en    = en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   always_comb begin
      state_d   = state_q;
      sout_d    = 1'b0;
      en_d      = 1'b0;
      done_d    = 1'b0;
      hist_d    = hist_q;
      sh_d      = sh_q;
      par_d     = par_q;
      rem_d     = rem_q;
      bcnt_d    = bcnt_q;
      gap_d     = gap_q;
      gap_inc   = gap_q + 1'b1;
      body      = 1'b0;
      enter_gap = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               state_d = PRE;
               sout_d  = 1'b1;
               en_d    = 1'b1;
               hist_d  = 3'b000;
               bcnt_d  = '0;
               gap_d   = '0;
               sh_d    = tx_data;
               par_d   = ^tx_data;
               rem_d   = RW'(BODY_BITS);
            end
         end
         PRE: begin
            // bcnt_q counts preamble bits already on the line: 1,2,3 -> 0,1,0
            if (bcnt_q < BCW'(4)) begin
               sout_d = ~bcnt_q[0];
               en_d   = 1'b1;
            end else begin
               body = 1'b1;
            end
         end
         DATA: body = 1'b1;
         TAIL: enter_gap = 1'b1;
         GAP: begin
            if (gap_q < GAP_LAST) begin
               gap_d  = gap_inc;
               done_d = (gap_inc == GAP_LAST);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Payload/parity emission. A history of 101 means a 0 now would
      // complete 1010, so a stuff 1 goes out instead.
      if (body) begin
         if (rem_q == '0) begin
            if (hist_q == 3'b101) begin
               state_d = TAIL;
               sout_d  = 1'b1;
               en_d    = 1'b1;
            end else begin
               enter_gap = 1'b1;
            end
         end else if (hist_q == 3'b101) begin
            state_d = DATA;
            sout_d  = 1'b1;
            en_d    = 1'b1;
         end else begin
            state_d = DATA;
            en_d    = 1'b1;
            rem_d   = rem_q - 1'b1;
            if ((PAR_BITS == 1) && (rem_q == RW'(1))) begin
               sout_d = par_q;
            end else begin
               sout_d = sh_q[DATA_W-1];
               sh_d   = {sh_q[DATA_W-2:0], 1'b0};
            end
         end
      end

      if (enter_gap) begin
         state_d = GAP;
         gap_d   = GW'(1);
         done_d  = (GAP_LAST == GW'(1));
      end

      // History and frame-bit count follow every bit driven with sout_en high
      if (en_d) begin
         hist_d = {hist_d[1:0], sout_d};
         bcnt_d = bcnt_d + 1'b1;
      end
   end

   // ---- control/output registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sout_q  <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hist_q  <= 3'b000;
         rem_q   <= '0;
         bcnt_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         sout_q  <= sout_d;
         en_q    <= en_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         hist_q  <= hist_d;
         rem_q   <= rem_d;
         bcnt_q  <= bcnt_d;
         gap_q   <= gap_d;
      end
   end

   // ---- payload data registers ----
   always_ff @(posedge clk) begin
      sh_q  <= sh_d;
      par_q <= par_d;
   end

endmodule

// File: tb/tb_preamble_stuff_tx.sv
// -----------------------------------------------------------------------------
// tb_preamble_stuff_tx
//
// Directed bench for preamble_stuff_tx (DATA_W = 8, GAP_BITS = 1). Expected
// line streams are written out by hand; a reference overlapping 1010 detector
// watches sout, and a de-stuffing receiver recovers random payloads.
// -----------------------------------------------------------------------------
module tb_preamble_stuff_tx;

`ifdef PREAMBLE_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       sout;
   logic       sout_en;
   logic       busy;
   logic       frame_done;

   int vectors = 0;
   int errors  = 0;
   int frames  = 0;

   preamble_stuff_tx #(.DATA_W(8), .GAP_BITS(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .sout       (sout),
      .sout_en    (sout_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference overlapping Mealy 1010 detector on the line
   logic [1:0] dst     = 2'd0;
   int         det_cnt = 0;
   int         det_bad = 0;
   int         run     = 0;

   always @(posedge clk) begin
      run <= (sout_en === 1'b1) ? run + 1 : 0;
      case (dst)
         2'd0: dst <= (sout === 1'b1) ? 2'd1 : 2'd0;
         2'd1: dst <= (sout === 1'b1) ? 2'd1 : 2'd2;
         2'd2: dst <= (sout === 1'b1) ? 2'd3 : 2'd0;
         default: begin
            if (sout === 1'b1) begin
               dst <= 2'd1;
            end else begin
               dst     <= 2'd2;
               det_cnt <= det_cnt + 1;
               if (!((sout_en === 1'b1) && (run == 3))) det_bad <= det_bad + 1;
            end
         end
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a payload and complete the handshake; leaves tx_valid low and
   // the sample point on the first preamble bit.
   task automatic send(input logic [7:0] d);
      int t;
      t        = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && t < 50) begin
         t++;
         step();
      end
      chk("ready_wait", tx_ready, 1'b1);
      step();
      tx_valid = 1'b0;
      frames++;
   endtask

   // Collect one frame MSB first; returns with the sample on the gap bit.
   task automatic get_frame(output logic [63:0] bits, output int n);
      int waited;
      int ctl_bad;
      bits    = '0;
      n       = 0;
      waited  = 0;
      ctl_bad = 0;
      while (sout_en !== 1'b1 && waited < 60) begin
         waited++;
         step();
      end
      chk("frame_start", sout_en, 1'b1);
      while (sout_en === 1'b1 && n < 64) begin
         bits = {bits[62:0], sout};
         n++;
         if (busy !== 1'b1 || frame_done !== 1'b0 || tx_ready !== 1'b0) ctl_bad++;
         step();
      end
      chk("frame_ctl", ctl_bad, 0);
      chk("gap_sout", sout, 1'b0);
      chk("gap_done", frame_done, 1'b1);
      chk("gap_busy", busy, 1'b1);
      chk("gap_ready", tx_ready, 1'b0);
   endtask

   task automatic idle_chk();
      step();
      chk("idle_ready", tx_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_line", {sout, sout_en, frame_done}, 3'b000);
   endtask

   // Receiver side: strip preamble and stuff bits, compare payload (+parity)
   task automatic decode(input logic [63:0] bits, input int n, input logic [7:0] d);
      logic [2:0]  h;
      logic [15:0] got;
      logic        b;
      int          cnt;
      int          bad;
      h   = 3'b010;
      got = '0;
      cnt = 0;
      bad = 0;
      chk("rnd_pre", (bits >> (n - 4)) & 64'hF, 64'hA);
      for (int i = n - 5; i >= 0; i--) begin
         b = bits[i];
         if (h == 3'b101) begin
            if (b !== 1'b1) bad++;
         end else begin
            got = {got[14:0], b};
            cnt++;
         end
         h = {h[1:0], b};
      end
      chk("rnd_stuff", bad, 0);
      chk("rnd_cnt", cnt, 8 + PB);
      chk("rnd_data", got >> PB, d);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("rnd_par", got[0], ^d);
`endif
   endtask

   logic [63:0] bits;
   int          n;
   int          done_seen;
   logic [7:0]  d;
   int          idle;
   int          t;

   initial begin
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      step();
      step();
      chk("rst_line", {sout, sout_en, busy, frame_done}, 4'b0000);
      chk("rst_ready", tx_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", tx_ready, 1'b1);

      // Single frame 0xA5: stuffs after payload bits 1 and 3 plus a trailing stuff
      send(8'hA5);
      chk("a5_latency", {sout, sout_en, busy}, 3'b111);
      get_frame(bits, n);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("a5_len", n, 16);
      chk("a5_bits", bits, 64'hAD96);
`else
      chk("a5_len", n, 15);
      chk("a5_bits", bits, 64'h56CB);
`endif
      idle_chk();

      // All zeros: no stuffing
      send(8'h00);
      get_frame(bits, n);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("z_len", n, 13);
      chk("z_bits", bits, 64'h1400);
`else
      chk("z_len", n, 12);
      chk("z_bits", bits, 64'hA00);
`endif
      idle_chk();

      // All ones: one stuff after the first payload bit
      send(8'hFF);
      get_frame(bits, n);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("ff_len", n, 14);
      chk("ff_bits", bits, 64'h2BFE);
`else
      chk("ff_len", n, 13);
      chk("ff_bits", bits, 64'h15FF);
`endif
      idle_chk();

      // Back-to-back with tx_valid held high
      t = det_cnt;
      chk("b2b_ready", tx_ready, 1'b1);
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      step();
      frames++;
      tx_data = 8'h0F;
      get_frame(bits, n);
      chk("b2b_f1_len", n, 15 + PB);
      step();
      chk("b2b_idle", {sout, sout_en, tx_ready}, 3'b001);
      step();
      frames++;
      tx_valid = 1'b0;
      chk("b2b_f2_start", {sout, sout_en}, 2'b11);
      get_frame(bits, n);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("b2b_f2_bits", bits, 64'h141E);
`else
      chk("b2b_f2_bits", bits, 64'hA0F);
`endif
      idle_chk();
      chk("b2b_detects", det_cnt - t, 2);
      chk("b2b_det_pos", det_bad, 0);

      // Reset asserted on cycle 6 of a frame
      send(8'hA5);
      repeat (5) step();
      chk("abort_c6", {sout, sout_en}, 2'b11);
      rst = 1'b1;
      #1;
      chk("abort_ready_rst", tx_ready, 1'b0);
      step();
      chk("abort_line", {sout, sout_en, busy, frame_done}, 4'b0000);
      rst = 1'b0;
      #1;
      chk("abort_ready", tx_ready, 1'b1);
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (frame_done !== 1'b0 || sout_en !== 1'b0) done_seen++;
      end
      chk("abort_quiet", done_seen, 0);
      send(8'hFF);
      get_frame(bits, n);
`ifdef PREAMBLE_TX_PARITY_EN
      chk("post_abort_bits", bits, 64'h2BFE);
`else
      chk("post_abort_bits", bits, 64'h15FF);
`endif
      idle_chk();

      // Random payloads, mixing back-to-back and idle spacing
      for (int r = 0; r < 40; r++) begin
         d    = 8'($urandom);
         idle = $urandom_range(0, 2);
         repeat (idle) step();
         send(d);
         get_frame(bits, n);
         decode(bits, n, d);
      end
      idle_chk();

      chk("det_total", det_cnt, frames);
      chk("det_pos", det_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
